// File: rtl/sa_tx_arbiter.sv
// sa_tx_arbiter: shares one UART transmitter between the column-result and
// row-result FIFOs. Each grant sends a source header byte followed by a burst
// of up to MAX_BURST bytes popped from the granted FIFO; bursts alternate
// round-robin when both sources have data.
module sa_tx_arbiter #(
    parameter int                W_DATA    = 8,
    parameter int                MAX_BURST = 16,
    parameter logic [W_DATA-1:0] HDR_COL   = 8'hC0,
    parameter logic [W_DATA-1:0] HDR_ROW   = 8'hA0
) (
    input  logic              i_clk,
    input  logic              i_rst_l,
    input  logic              i_col_valid,
    input  logic [W_DATA-1:0] i_col_data,
    output logic              o_col_rd,
    input  logic              i_row_valid,
    input  logic [W_DATA-1:0] i_row_data,
    output logic              o_row_rd,
    output logic              o_tx_dv,
    output logic [W_DATA-1:0] o_tx_byte,
    input  logic              i_tx_active,
    input  logic              i_tx_done,
    output logic [1:0]        o_grant,
    output logic              o_busy
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        HDR_WAIT,
        DATA,
        DATA_WAIT
    } state_t;

    localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

    state_t            state;
    logic [7:0]        burst_cnt;
    logic              last_row;
    logic              pick_row;
    logic              src_valid;
    logic [W_DATA-1:0] src_data;
    logic              end_burst;

    // Source selection: the owner's FIFO head while busy, and the round-robin winner while idle.
    always_comb begin
        pick_row  = i_row_valid && (!i_col_valid || !last_row);
        src_valid = o_grant[1] ? i_row_valid : i_col_valid;
        src_data  = o_grant[1] ? i_row_data  : i_col_data;
        end_burst = 1'b0;
        if (state == DATA && !i_tx_active && !src_valid) begin
            end_burst = 1'b1;
        end
        if (state == DATA_WAIT && i_tx_done && burst_cnt == BURST_LIMIT) begin
            end_burst = 1'b1;
        end
    end

    // Burst sequencer: grant, header, data bytes, then release with round-robin bookkeeping.
    always_ff @(posedge i_clk or negedge i_rst_l) begin
        if (!i_rst_l) begin
            state     <= IDLE;
            o_tx_dv   <= 1'b0;
            o_tx_byte <= '0;
            o_col_rd  <= 1'b0;
            o_row_rd  <= 1'b0;
            o_grant   <= 2'b00;
            o_busy    <= 1'b0;
            burst_cnt <= 8'd0;
            last_row  <= 1'b1;
        end else begin
            o_tx_dv  <= 1'b0;
            o_col_rd <= 1'b0;
            o_row_rd <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_col_valid || i_row_valid) begin
                        o_grant <= pick_row ? 2'b10 : 2'b01;
                        o_busy  <= 1'b1;
                        state   <= HDR;
                    end
                end
                HDR: begin
                    if (!i_tx_active) begin
                        o_tx_dv   <= 1'b1;
                        o_tx_byte <= o_grant[1] ? HDR_ROW : HDR_COL;
                        state     <= HDR_WAIT;
                    end
                end
                HDR_WAIT: begin
                    if (i_tx_done) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (!i_tx_active && src_valid) begin
                        o_tx_dv   <= 1'b1;
                        o_tx_byte <= src_data;
                        o_col_rd  <= !o_grant[1];
                        o_row_rd  <= o_grant[1];
                        burst_cnt <= burst_cnt + 8'd1;
                        state     <= DATA_WAIT;
                    end
                end
                DATA_WAIT: begin
                    if (i_tx_done) begin
                        state <= DATA;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if (end_burst) begin
                state     <= IDLE;
                burst_cnt <= 8'd0;
                last_row  <= o_grant[1];
                o_grant   <= 2'b00;
                o_busy    <= 1'b0;
            end
        end
    end

endmodule
